// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared constants, op codes and scheduler state encoding for au and au_scheduler
package au_pkg;

    localparam int AU_DW = 2;
    localparam int AU_YW = 2 * AU_DW;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/au_scheduler_if.sv
// rtl/au_scheduler_if.sv - requester and ALU side signal bundle of au_scheduler
interface au_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 2,
    parameter int YW   = 4
);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*2-1:0]  req_ctrl;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [YW-1:0]      rsp_y;
    logic               rsp_c;
    logic               rsp_err;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [1:0]         alu_ctrl;
    logic               alu_start;
    logic [YW-1:0]      alu_y;
    logic               alu_c;
    logic               alu_done;
    logic               busy;

    // slave: the scheduler itself
    modport slave (
        input  req, req_a, req_b, req_ctrl, alu_y, alu_c, alu_done,
        output gnt, rsp_valid, rsp_y, rsp_c, rsp_err,
               alu_a, alu_b, alu_ctrl, alu_start, busy
    );

    // master: requesters plus the ALU, as seen from outside the scheduler
    modport master (
        output req, req_a, req_b, req_ctrl, alu_y, alu_c, alu_done,
        input  gnt, rsp_valid, rsp_y, rsp_c, rsp_err,
               alu_a, alu_b, alu_ctrl, alu_start, busy
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or above ptr, wrapping
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    logic [PW:0] slot;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        slot  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // one spare bit so ptr+k can exceed NREQ-1 before wrapping
            slot = {1'b0, ptr_i} + (PW+1)'(k);
            if (slot >= (PW+1)'(NREQ)) begin
                slot = slot - (PW+1)'(NREQ);
            end
            if (!any_o && req_i[slot[PW-1:0]]) begin
                any_o = 1'b1;
                idx_o = slot[PW-1:0];
            end
        end
        gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/au_scheduler.sv
// rtl/au_scheduler.sv - round-robin sharing of one multi-cycle ALU; AU_SCHED_TIMEOUT_EN adds a WAIT timeout
module au_scheduler
    import au_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = AU_DW,
    parameter int YW      = AU_YW,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    au_scheduler_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || YW != 2 * DW) begin : g_bad_cfg
        $error("au_scheduler: unsupported parameter set");
    end

    sched_state_t    state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [1:0]      alu_ctrl_q, alu_ctrl_d;
    logic            alu_start_q, alu_start_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [YW-1:0]   rsp_y_q, rsp_y_d;
    logic            rsp_c_q, rsp_c_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

`ifdef AU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
`endif

    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_any;
    logic [NREQ-1:0] owner_oh;

    logic [DW-1:0]   a_arr    [NREQ];
    logic [DW-1:0]   b_arr    [NREQ];
    logic [1:0]      ctrl_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]    = bus.req_a[i*DW +: DW];
            b_arr[i]    = bus.req_b[i*DW +: DW];
            ctrl_arr[i] = bus.req_ctrl[i*2 +: 2];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign owner_oh = NREQ'(1) << owner_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_start_d = 1'b0;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_y_d     = rsp_y_q;
        rsp_c_d     = rsp_c_q;
        rsp_err_d   = rsp_err_q;
`ifdef AU_SCHED_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    owner_d    = win_idx;
                    alu_a_d    = a_arr[win_idx];
                    alu_b_d    = b_arr[win_idx];
                    alu_ctrl_d = ctrl_arr[win_idx];
                    gnt_d      = win_oh;
                    // divide-by-zero answers directly and never occupies the ALU
                    if (ctrl_arr[win_idx] == OP_DIV && b_arr[win_idx] == '0) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = win_oh;
                        rsp_y_d     = '0;
                        rsp_c_d     = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        alu_start_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef AU_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = owner_oh;
                    rsp_y_d     = bus.alu_y;
                    rsp_c_d     = bus.alu_c;
                    rsp_err_d   = 1'b0;
                end
`ifdef AU_SCHED_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = owner_oh;
                    rsp_y_d     = '0;
                    rsp_c_d     = 1'b0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            alu_start_q <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rsp_c_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AU_SCHED_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_start_q <= alu_start_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_c_q     <= rsp_c_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
`ifdef AU_SCHED_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.alu_start = alu_start_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/au_scheduler.md
# au_scheduler

Round-robin scheduler that shares one multi-cycle ALU (`au`: 2-bit operands, 2-bit op code, 4-bit result `y`, carry/flag `c`, `done` completion) among NREQ requesters. Arbitrates, captures the winner's operands, launches one ALU operation, waits for `done`, and routes the result back to the owner. Divide-by-zero is short-circuited without occupying the ALU. Sits between requester blocks and the single `au` instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 2, operand width per requester
- YW, 4, result width (2*DW)
- TIMEOUT, 16, max cycles waiting for `alu_done` (used only with AU_SCHED_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; held with operands until matching `gnt`
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- req_ctrl  in  NREQ*2  op code, 00 ADD, 01 SUB, 10 MUL, 11 DIV
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: result for requester i valid
- rsp_y  out  YW  result, valid with `rsp_valid`
- rsp_c  out  1  ALU flag, valid with `rsp_valid`
- rsp_err  out  1  error (divide-by-zero or timeout), valid with `rsp_valid`
- alu_a, alu_b  out  DW each  operands to ALU, held stable ISSUE through WAIT
- alu_ctrl  out  2  op code to ALU
- alu_start  out  1  one-cycle launch pulse
- alu_y  in  YW  ALU result; alu_c  in  1  ALU flag; alu_done  in  1  completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req`, winner = first set bit at or above `ptr`, wrapping modulo NREQ. On the edge: capture winner's a/b/ctrl into `alu_a/b/ctrl`, record owner. Next state ISSUE; if ctrl==11 and b==0, next state RESP with y=0, c=0, err=1 (ALU never started).
- ISSUE: `gnt[owner]`=1, `alu_start`=1 for exactly this cycle; next WAIT. For the div-0 path, `gnt[owner]` is instead asserted in the IDLE->RESP cycle, i.e. in RESP's cycle, with no `alu_start`.
- WAIT: on `alu_done`, register `alu_y`, `alu_c`, err=0; next RESP. `alu_done` outside WAIT is ignored.
- RESP: `rsp_valid[owner]`=1 for one cycle with registered y/c/err; `ptr` <= (owner+1) mod NREQ; next IDLE.
- Fairness: a requester holding `req` is served within NREQ transactions. A requester that reasserts immediately after `rsp_valid` is re-eligible only after `ptr` rotation.
- `req` drop before `gnt`: the transaction already captured still completes and responds.
- Reset (any time, including mid-WAIT): state IDLE, `ptr`=0, in-flight op dropped with no response; all outputs 0, including `gnt`, `rsp_valid`, `rsp_y`, `rsp_c`, `rsp_err`, `alu_a`, `alu_b`, `alu_ctrl`, `alu_start`, `busy`.

## Timing
- All outputs registered; no combinational input-to-output paths.
- ALU path: `req` sampled in IDLE at edge N; `gnt` and `alu_start` high in cycle N+1; ALU `done` at N+1+L; `rsp_valid` in cycle N+2+L. Next arbitration edge at N+3+L.
- Div-0 path: `gnt` and `rsp_valid` both high in cycle N+1; next arbitration at N+2.
- Back-to-back throughput with a continuously asserted `req`: one op per L+3 cycles.

## Configuration
- AU_SCHED_TIMEOUT_EN defined:
  - WAIT state has a cycle counter.
  - If `alu_done` has not arrived after TIMEOUT cycles in WAIT, go to RESP with y=0, c=0, err=1.
  - A `done` arriving later is ignored, because it falls outside WAIT.
- Undefined: no counter; WAIT holds indefinitely until `alu_done`.

## Structure
- Shared package `au_pkg`:
  - op-code constants OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - FSM state encoding.
  - default DW/YW constants, shared with `au`.
- Sub-module `rr_pick`: combinational round-robin picker (req, ptr -> one-hot winner, any). Instantiated once.

## Test plan
- Single op: req[0], a=2, b=1, ADD, ALU done after L=2 -> `gnt[0]` at N+1, `rsp_valid[0]` at N+4, y=3, err=0.
- Contention: req=4'b1111, all MUL a=2 b=2, starting ptr=0 -> grant order 0,1,2,3,0, each y=4, no starvation.
- Div-0: req[2], a=2, b=0, DIV -> `gnt[2]` and `rsp_valid[2]` same cycle, y=0, err=1, `alu_start` never asserted.
- Reset mid-WAIT: assert reset_n=0 during WAIT -> all outputs 0 immediately; no `rsp_valid`; next req granted from ptr=0.
- Timeout (macro on, TIMEOUT=16): withhold `alu_done` -> `rsp_valid` after 16 WAIT cycles with err=1; a late `done` has no effect. Macro off: stays in WAIT.
- Stray `alu_done` in IDLE/ISSUE -> ignored; no `rsp_valid`.
